// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: keypad matrix pins plus the key event/value outputs.
// Latency: none (wires only).
// Backpressure: none; key_event is a level the consumer samples at will.
interface keypad_scanner_if;
    logic       scan_en;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic       key_event;
    logic [3:0] key_value;
    logic       key_press;

    // Scanner side: drives rows and key outputs, reads columns and enable.
    modport master (
        input  scan_en,
        input  col_in,
        output row_out,
        output key_event,
        output key_value,
        output key_press
    );

    // Consumer/keypad side: the mirror image of the scanner.
    modport slave (
        output scan_en,
        output col_in,
        input  row_out,
        input  key_event,
        input  key_value,
        input  key_press
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce; KEYPAD_PHONE_MAP_EN selects telephone key codes.
// Latency: 2 sync clocks + up to 4*SCAN_DIV scan clocks + DEBOUNCE_CNT clocks from stable press to key_event.
// Backpressure: none; key_event is held from debounced press to debounced release, scan_en=0 forces idle.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    localparam int MAXP = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW   = $clog2(MAXP);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CNT - 1);
    // The PRESSED clock that first saw the column high is already the first of
    // the stable-high run, so RELEASE needs one clock fewer of its own.
    localparam logic [CW-1:0] REL_LAST = CW'(DEBOUNCE_CNT - 2);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state;
    logic [3:0]    cs_meta;
    logic [3:0]    cs;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    row;
    logic [1:0]    row_nxt;
    logic [1:0]    lat_col;
    logic [3:0]    row_drv_q;
    logic          key_event_q;
    logic [3:0]    key_value_q;
    logic          key_press_q;

    // Lowest-index low column wins when several keys share the scanned row.
    function automatic logic [1:0] first_low(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] row_drv(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
`ifdef KEYPAD_PHONE_MAP_EN
        logic [3:0] code;
        case ({r, c})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
`else
        return {r, c};
`endif
    endfunction

    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
    assign row_nxt = row + 2'd1;

    // Two-flop synchroniser for the asynchronous column inputs; idle level is all-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_meta <= 4'hF;
            cs      <= 4'hF;
        end else begin
            cs_meta <= kp.col_in;
            cs      <= cs_meta;
        end
    end

    // Scan/debounce FSM with registered row drive and key outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SCAN;
            cnt         <= '0;
            row         <= 2'd0;
            lat_col     <= 2'd0;
            row_drv_q   <= 4'b1110;
            key_event_q <= 1'b0;
            key_value_q <= 4'd0;
            key_press_q <= 1'b0;
        end else begin
            key_press_q <= 1'b0;
            if (!kp.scan_en) begin
                state       <= SCAN;
                cnt         <= '0;
                row         <= 2'd0;
                row_drv_q   <= 4'b1110;
                key_event_q <= 1'b0;
            end else begin
                case (state)
                    SCAN: begin
                        if (cnt == DIV_LAST) begin
                            cnt <= '0;
                            if (cs != 4'hF) begin
                                lat_col <= first_low(cs);
                                state   <= DEBOUNCE;
                            end else begin
                                row       <= row_nxt;
                                row_drv_q <= row_drv(row_nxt);
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    DEBOUNCE: begin
                        if (cs[lat_col]) begin
                            state     <= SCAN;
                            cnt       <= '0;
                            row       <= row_nxt;
                            row_drv_q <= row_drv(row_nxt);
                        end else if (cnt == DB_LAST) begin
                            state       <= PRESSED;
                            cnt         <= '0;
                            key_event_q <= 1'b1;
                            key_value_q <= key_map(row, lat_col);
                            key_press_q <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    PRESSED: begin
                        if (cs[lat_col]) begin
                            state <= RELEASE;
                            cnt   <= '0;
                        end
                    end
                    RELEASE: begin
                        if (!cs[lat_col]) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == REL_LAST) begin
                            state       <= SCAN;
                            cnt         <= '0;
                            key_event_q <= 1'b0;
                            row         <= row_nxt;
                            row_drv_q   <= row_drv(row_nxt);
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    assign kp.row_out   = row_drv_q;
    assign kp.key_event = key_event_q;
    assign kp.key_value = key_value_q;
    assign kp.key_press = key_press_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed key sequences, scoreboard monitor.
// Latency: expected event timing derived from SCAN_DIV=4, DEBOUNCE_CNT=8.
// Backpressure: none; the monitor samples every falling clock edge.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 8;

    typedef struct {
        bit         rise;
        logic [3:0] val;
        logic [3:0] row;
        int         cyc;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    logic [15:0] keys = 16'h0;
    int        cyc = 0;
    int        n_chk = 0;
    int        n_pass = 0;
    exp_t      sb[$];

    keypad_scanner_if kif();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk(clk),
        .rst(rst),
        .kp (kif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive matrix: a held key pulls its column low while its row is driven low.
    always_comb begin
        kif.col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.row_out[r]) kif.col_in[c] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] row_pat(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << r);
    endfunction

    function automatic logic [3:0] code(input int r, input int c);
`ifdef KEYPAD_PHONE_MAP_EN
        case (r*4 + c)
            0: return 4'h1;   1: return 4'h2;   2: return 4'h3;   3: return 4'hA;
            4: return 4'h4;   5: return 4'h5;   6: return 4'h6;   7: return 4'hB;
            8: return 4'h7;   9: return 4'h8;  10: return 4'h9;  11: return 4'hC;
           12: return 4'hE;  13: return 4'h0;  14: return 4'hF;
            default: return 4'hD;
        endcase
`else
        return 4'(r*4 + c);
`endif
    endfunction

    task automatic expect_rise(input logic [3:0] v);
        exp_t e;
        e.rise = 1'b1; e.val = v; e.row = 4'h0; e.cyc = 0;
        sb.push_back(e);
    endtask

    task automatic expect_fall(input logic [3:0] v, input logic [3:0] row, input int at);
        exp_t e;
        e.rise = 1'b0; e.val = v; e.row = row; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic wait_row(input logic [3:0] pat, input int max);
        for (int i = 0; i < max && kif.row_out != pat; i++) @(negedge clk);
        check("wait_row", int'(kif.row_out), int'(pat));
    endtask

    task automatic wait_ev(input logic lvl, input int max);
        for (int i = 0; i < max && kif.key_event != lvl; i++) @(negedge clk);
        check("wait_event", int'(kif.key_event), int'(lvl));
    endtask

    // Press key (r,c) during the row before r so that row r gets a full scan period.
    task automatic press_key(input int r, input int c);
        wait_row(row_pat((r + 3) % 4), 40);
        keys[r*4+c] = 1'b1;
    endtask

    // Full press/hold/release of one key with its expected events.
    task automatic do_key(input int r, input int c, input int hold);
        press_key(r, c);
        expect_rise(code(r, c));
        wait_ev(1'b1, 60);
        repeat (hold) @(negedge clk);
        keys[r*4+c] = 1'b0;
        expect_fall(code(r, c), row_pat((r + 1) % 4), cyc + 2 + DB);
        wait_ev(1'b0, 40);
    endtask

    // Scoreboard monitor: pops one expectation on every key_event edge.
    initial begin : monitor
        logic       prev_ev;
        logic [3:0] prev_row;
        logic [3:0] prev_val;
        int         row_cyc;
        exp_t       e;
        prev_ev = 1'b0; prev_row = 4'b1110; prev_val = 4'd0; row_cyc = 0;
        forever begin
            @(negedge clk);
            if (kif.row_out != prev_row) row_cyc = cyc;
            if (kif.key_press)
                check("press_only_on_rise", int'(kif.key_event && !prev_ev), 1);
            if (kif.key_event && prev_ev)
                check("value_stable", int'(kif.key_value), int'(prev_val));
            if (kif.key_event != prev_ev) begin
                check("event_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("event_dir", int'(kif.key_event), int'(e.rise));
                    check("event_value", int'(kif.key_value), int'(e.val));
                    if (kif.key_event) begin
                        check("press_strobe", int'(kif.key_press), 1);
                        check("rise_latency", cyc - row_cyc, SD + DB);
                    end else begin
                        check("fall_cycle", cyc, e.cyc);
                        check("fall_row", int'(kif.row_out), int'(e.row));
                    end
                end
            end
            prev_ev  = kif.key_event;
            prev_row = kif.row_out;
            prev_val = kif.key_value;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int x;
        kif.scan_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_row", int'(kif.row_out), 4'b1110);
        check("rst_event", int'(kif.key_event), 0);
        check("rst_value", int'(kif.key_value), 0);
        check("rst_press", int'(kif.key_press), 0);
        rst = 1'b1;

        // Idle scan: each row held SD clocks, wrapping 3 -> 0.
        for (int i = 0; i < 20; i++) begin
            check("scan_row", int'(kif.row_out), int'(row_pat((i / 4) % 4)));
            check("idle_event", int'(kif.key_event), 0);
            @(negedge clk);
        end

        // Stable press row2/col1, release resumes at row 3.
        do_key(2, 1, 5);

        // Press bounce: column low for 3 debounce clocks, then released.
        wait_row(row_pat(2), 40);
        x = cyc;
        keys[9] = 1'b1;
        repeat (5) @(negedge clk);
        keys[9] = 1'b0;
        for (int i = 0; i < 16 && kif.row_out == row_pat(2); i++) @(negedge clk);
        check("bounce_next_row", int'(kif.row_out), int'(row_pat(3)));
        check("bounce_resume", cyc - x, 8);

        // Release bounce: 3 clocks high then low again, key stays held.
        press_key(2, 1);
        expect_rise(code(2, 1));
        wait_ev(1'b1, 60);
        repeat (2) @(negedge clk);
        keys[9] = 1'b0;
        repeat (3) @(negedge clk);
        keys[9] = 1'b1;
        repeat (12) @(negedge clk);
        check("release_bounce_held", int'(kif.key_event), 1);
        keys[9] = 1'b0;
        expect_fall(code(2, 1), row_pat(3), cyc + 2 + DB);
        wait_ev(1'b0, 40);

        // Two keys in row 1, then a row-3 key invisible until release completes.
        press_key(1, 1);
        keys[7] = 1'b1;
        expect_rise(code(1, 1));
        wait_ev(1'b1, 60);
        keys[13] = 1'b1;
        repeat (20) @(negedge clk);
        keys[5] = 1'b0;
        keys[7] = 1'b0;
        expect_fall(code(1, 1), row_pat(2), cyc + 2 + DB);
        expect_rise(code(3, 1));
        wait_ev(1'b0, 40);
        wait_ev(1'b1, 40);
        repeat (3) @(negedge clk);
        keys[13] = 1'b0;
        expect_fall(code(3, 1), row_pat(0), cyc + 2 + DB);
        wait_ev(1'b0, 40);

        // scan_en dropped while a key is held.
        press_key(1, 2);
        expect_rise(code(1, 2));
        wait_ev(1'b1, 60);
        repeat (2) @(negedge clk);
        kif.scan_en = 1'b0;
        expect_fall(code(1, 2), 4'b1110, cyc + 1);
        repeat (4) begin
            @(negedge clk);
            check("disabled_row", int'(kif.row_out), 4'b1110);
        end
        keys = 16'h0;
        kif.scan_en = 1'b1;

        // Asynchronous reset in the middle of DEBOUNCE.
        press_key(2, 1);
        wait_row(row_pat(2), 40);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_row", int'(kif.row_out), 4'b1110);
        check("midrst_event", int'(kif.key_event), 0);
        check("midrst_value", int'(kif.key_value), 0);
        check("midrst_press", int'(kif.key_press), 0);
        keys = 16'h0;
        @(negedge clk);
        rst = 1'b1;

        // Row-3 keys exercise the map differences between builds.
        do_key(3, 1, 3);
        do_key(3, 0, 3);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad, debounces press and release, and presents one key to the password FSM.
- Sits directly upstream of the password FSM and drives its key event/value inputs.
- key_event is a debounced level: high from debounced press to debounced release. The FSM stores the key on the high level and re-arms when it goes low.

Parameters:
- SCAN_DIV, 1000: clocks each row is driven before its columns are sampled; minimum 4.
- DEBOUNCE_CNT, 20000: consecutive stable clocks needed to accept a press or a release; minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- scan_en  input  1  scanning enable (tied to the FSM's active mode); low forces idle
- col_in  input  4  keypad columns, active-low, externally pulled up, asynchronous
- row_out  output  4  keypad rows, active-low, exactly one bit low at all times
- key_event  output  1  debounced key-held level
- key_value  output  4  code of the held key; valid and stable while key_event=1
- key_press  output  1  one-clock strobe on the clock key_event rises

Behaviour:
- Reset values: row_out=4'b1110 (row 0), key_event=0, key_value=0, key_press=0, state=SCAN, all counters 0.
- col_in passes through a 2-flop synchroniser; all decisions use synchronised columns (cs).
- Counter widths are $clog2 of the larger parameter; counters saturate, never wrap.
- SCAN:
  - div counter counts 0..SCAN_DIV-1 while the current row r is driven.
  - At div=SCAN_DIV-1, cs is sampled.
  - If any bit is low: latch r and the lowest-index low column c, clear the counter, go to DEBOUNCE.
  - If no bit is low: advance r (3 wraps to 0) and clear div.
- DEBOUNCE:
  - row_out is frozen on the latched row.
  - Each clock cs[c]=0: counter increments.
  - cs[c]=1 at any point: no event; return to SCAN at the next row.
  - When the counter reaches DEBOUNCE_CNT-1 with cs[c]=0: next clock key_event=1, key_value=map(r,c), key_press=1 for that clock only; go to PRESSED.
- PRESSED:
  - row_out stays frozen; key_event and key_value are held.
  - Other columns and other rows are ignored.
  - cs[c]=1: clear counter, go to RELEASE.
- RELEASE:
  - key_event stays 1.
  - cs[c]=0 again: clear counter, return to PRESSED (release bounce absorbed).
  - cs[c]=1 for DEBOUNCE_CNT consecutive clocks: key_event=0 next clock, key_value retains its last code, go to SCAN at the next row with div=0.
- Default map: key_value = {r[1:0], c[1:0]}, i.e. r*4+c.
- Multiple keys pressed:
  - Within the latched row, the lowest column wins.
  - A second key in another row is invisible until the release completes.
- scan_en=0, synchronous, highest priority after reset: next clock key_event=0, key_press=0, state=SCAN, row 0, counters cleared. Scanning is held until scan_en returns to 1.
- Reset mid-operation (any state): immediate return to the reset values.
- Latency from stable press to key_event: 2 sync clocks + up to 4*SCAN_DIV scan clocks + DEBOUNCE_CNT clocks.

Optional Feature:
- Macro: KEYPAD_PHONE_MAP_EN.
- Defined: key_value uses the telephone layout:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E(*),0,F(#),D
- Undefined: key_value uses the default linear map r*4+c.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset, SCAN_DIV=4, DEBOUNCE_CNT=8, scan_en=1, no key:
  - row_out=1110 after reset, then 1101, 1011, 0111, 1110, each held 4 clocks.
  - key_event=0 and key_press=0 throughout.
- Stable press row2/col1, default map:
  - key_event rises 8 clocks after the row-2 sample; key_value=4'd9; key_press high exactly 1 clock.
  - Release: key_event falls 8 clocks after cs[1] goes high; scanning resumes at row 3.
- Press bounce, col1 low for 3 clocks then high:
  - No key_event and no key_press; scanning resumes at the next row.
- Release bounce, col high 3 clocks then low again during PRESSED:
  - key_event stays 1; key_value unchanged.
- Row1 cols 1 and 3 pressed together:
  - key_value=4'd5.
  - A row3 key added while held produces no change until the release completes.
- scan_en dropped during PRESSED:
  - key_event=0 next clock; row_out=1110.
- rst asserted mid-DEBOUNCE:
  - Immediate reset values.
- With KEYPAD_PHONE_MAP_EN, press row3/col1:
  - key_value=4'd0; row3/col0 gives 4'hE.
